// File: rtl/reset_release_seq.sv
// Reset release sequencer: synchronizes the deasserting edge of RST, holds the
// generated reset low for a fixed number of cycles, and accepts software resets.
module reset_release_seq #(
    parameter int stages = 2,
    parameter int hold   = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ASSERT_IN,
    output logic       ASSERT_OUT,
    output logic       OUT_RST,
    output logic       IS_RESET,
    output logic [7:0] COUNT
);

    typedef enum logic [1:0] {
        RESET = 2'd0,
        SYNC  = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(hold - 1);

    state_t            state_reg, state_next;
    logic [stages-1:0] sync_reg;
    logic [7:0]        count_reg, count_next;
    logic              out_rst_reg;
    logic              ack_reg;
    logic              accept;

    // Shift register fills with ones once RST is released; it only matters
    // while waiting in SYNC, afterwards it simply stays saturated.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[stages-2:0], 1'b1};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= RESET;
            count_reg   <= 8'd0;
            out_rst_reg <= 1'b0;
            ack_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            out_rst_reg <= (state_next == RUN);
            ack_reg     <= accept;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = 8'd0;
        accept     = 1'b0;
        case (state_reg)
            RESET: state_next = SYNC;
            SYNC: begin
                // Bit stages-2 set now means the last bit becomes 1 on this edge.
                if (sync_reg[stages-2]) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // A request wins over the release edge and restarts the hold.
                if (ASSERT_IN) begin
                    accept = 1'b1;
                end else if (count_reg == HOLD_LAST) begin
                    state_next = RUN;
                end else begin
                    count_next = 8'(count_reg + 8'd1);
                end
            end
            RUN: begin
                if (ASSERT_IN) begin
                    accept     = 1'b1;
                    state_next = HOLD;
                end
            end
            default: state_next = RESET;
        endcase
    end

    assign OUT_RST    = out_rst_reg;
    assign IS_RESET   = ~out_rst_reg;
    assign ASSERT_OUT = ack_reg;
    assign COUNT      = count_reg;

endmodule

// File: tb/tb_reset_release_seq.sv
// Bench for reset_release_seq: power-on vector table, directed corner cases and
// random requests/reset pulses compared against an edge-counting reference model.
module tb_reset_release_seq;

    localparam int STAGES = 2;
    localparam int HOLD   = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       ASSERT_IN = 1'b0;
    logic       ASSERT_OUT;
    logic       OUT_RST;
    logic       IS_RESET;
    logic [7:0] COUNT;

    int checks   = 0;
    int failures = 0;

    // Reference model: edges since RST rose, and the edge on which the current
    // hold period started (power-on hold starts on edge STAGES).
    int m_e   = 0;
    int m_ref = STAGES;
    bit m_ack = 1'b0;
    int edge_no = 0;

    typedef struct {
        bit ain;
        int out;
        int cnt;
        int ack;
    } vec_t;
    vec_t tbl[12];

    reset_release_seq #(.stages(STAGES), .hold(HOLD)) dut (
        .CLK(CLK),
        .RST(RST),
        .ASSERT_IN(ASSERT_IN),
        .ASSERT_OUT(ASSERT_OUT),
        .OUT_RST(OUT_RST),
        .IS_RESET(IS_RESET),
        .COUNT(COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_no);
        end
    endtask

    function automatic int exp_out();
        return (m_e >= m_ref + HOLD) ? 1 : 0;
    endfunction

    function automatic int exp_cnt();
        return (m_e >= m_ref && m_e < m_ref + HOLD) ? (m_e - m_ref) : 0;
    endfunction

    task automatic model_reset();
        m_e   = 0;
        m_ref = STAGES;
        m_ack = 1'b0;
    endtask

    task automatic model_edge(input bit rst, input bit ain);
        if (!rst) begin
            model_reset();
        end else begin
            m_e++;
            m_ack = 1'b0;
            // The block is in HOLD or RUN before this edge once STAGES edges have passed.
            if (ain && (m_e - 1 >= STAGES)) begin
                m_ref = m_e;
                m_ack = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " out_rst"}, int'(OUT_RST), exp_out());
        chk({tag, " is_reset"}, int'(IS_RESET), 1 - exp_out());
        chk({tag, " count"}, int'(COUNT), exp_cnt());
        chk({tag, " ack"}, int'(ASSERT_OUT), int'(m_ack));
    endtask

    task automatic do_edge(input bit ain, input string tag);
        ASSERT_IN = ain;
        @(posedge CLK);
        edge_no++;
        model_edge(RST, ain);
        #1;
        check_model(tag);
        $display("edge %0d %s rst=%0b ain=%0b out_rst=%0b count=%0d ack=%0b",
                 edge_no, tag, RST, ain, OUT_RST, COUNT, ASSERT_OUT);
    endtask

    // Short asynchronous reset pulse between edges; outputs must react without a clock.
    task automatic async_pulse(input string tag);
        #2 RST = 1'b0;
        model_reset();
        #1;
        chk({tag, " async out_rst"}, int'(OUT_RST), 0);
        chk({tag, " async is_reset"}, int'(IS_RESET), 1);
        chk({tag, " async count"}, int'(COUNT), 0);
        chk({tag, " async ack"}, int'(ASSERT_OUT), 0);
        $display("async reset pulse %s out_rst=%0b count=%0d", tag, OUT_RST, COUNT);
        #1 RST = 1'b1;
    endtask

    task automatic edges_to_release(input string tag, input int exp_n, input int bound);
        int n;
        n = 0;
        while (!OUT_RST && n < bound) begin
            do_edge(1'b0, tag);
            n++;
        end
        chk({tag, " release edges"}, n, exp_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Power-on: ASSERT_IN high on edges 1-2 (RESET/SYNC) is ignored,
        // then a single request on edge 11 once in RUN.
        tbl[0]  = '{1'b1, 0, 0, 0};
        tbl[1]  = '{1'b1, 0, 0, 0};
        tbl[2]  = '{1'b0, 0, 1, 0};
        tbl[3]  = '{1'b0, 0, 2, 0};
        tbl[4]  = '{1'b0, 0, 3, 0};
        tbl[5]  = '{1'b0, 0, 4, 0};
        tbl[6]  = '{1'b0, 0, 5, 0};
        tbl[7]  = '{1'b0, 0, 6, 0};
        tbl[8]  = '{1'b0, 0, 7, 0};
        tbl[9]  = '{1'b0, 1, 0, 0};
        tbl[10] = '{1'b1, 0, 0, 1};
        tbl[11] = '{1'b0, 0, 1, 0};

        repeat (3) @(posedge CLK);
        #1;
        chk("reset out_rst", int'(OUT_RST), 0);
        chk("reset is_reset", int'(IS_RESET), 1);
        chk("reset count", int'(COUNT), 0);
        chk("reset ack", int'(ASSERT_OUT), 0);
        RST = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_edge(tbl[i].ain, "table");
            chk("table out_rst", int'(OUT_RST), tbl[i].out);
            chk("table count", int'(COUNT), tbl[i].cnt);
            chk("table ack", int'(ASSERT_OUT), tbl[i].ack);
        end

        // Re-request in HOLD when COUNT=5.
        n = 0;
        while (COUNT != 8'd5 && n < 10) begin
            do_edge(1'b0, "hold_wait");
            n++;
        end
        chk("count reached 5", int'(COUNT), 5);
        do_edge(1'b1, "rerequest");
        chk("rerequest count", int'(COUNT), 0);
        chk("rerequest ack", int'(ASSERT_OUT), 1);
        edges_to_release("rerequest", HOLD, 20);

        // Request coincident with the HOLD->RUN edge.
        do_edge(1'b1, "run_req");
        n = 0;
        while (COUNT != 8'd7 && n < 12) begin
            do_edge(1'b0, "to_last");
            n++;
        end
        chk("edges to count 7", n, 7);
        do_edge(1'b1, "coincident");
        chk("coincident out_rst", int'(OUT_RST), 0);
        chk("coincident count", int'(COUNT), 0);
        chk("coincident ack", int'(ASSERT_OUT), 1);
        edges_to_release("coincident", HOLD, 20);

        // Continuous request keeps reset asserted with back-to-back acks.
        for (int i = 0; i < 20; i++) begin
            do_edge(1'b1, "held");
        end
        chk("held out_rst", int'(OUT_RST), 0);
        edges_to_release("held", HOLD, 20);

        // Async reset mid-HOLD at COUNT=4.
        do_edge(1'b1, "pre_abort");
        for (int i = 0; i < 4; i++) begin
            do_edge(1'b0, "to_four");
        end
        chk("mid-hold count", int'(COUNT), 4);
        async_pulse("mid_hold");
        edges_to_release("after_hold_abort", STAGES + HOLD, 20);

        // Async reset mid-SYNC.
        async_pulse("pre_sync");
        do_edge(1'b1, "sync");
        async_pulse("mid_sync");
        edges_to_release("after_sync_abort", STAGES + HOLD, 20);

        // Random requests and occasional short reset pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                async_pulse("random");
            end
            do_edge($urandom_range(0, 5) == 0, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reset_release_seq.md
RESET_RELEASE_SEQ -- requirements
Module: reset_release_seq

Interface
REQ-001 The module SHALL have parameter stages, default 2, meaning synchronizer depth; legal range 2..4.
REQ-002 The module SHALL have parameter hold, default 8, meaning the reset hold length in CLK cycles; legal range 1..255.
REQ-003 Port CLK  input  1  the single clock; all state SHALL be on its rising edge.
REQ-004 Port RST  input  1  reset, asynchronous and active-low.
REQ-005 Port ASSERT_IN  input  1  software reset request, sampled high on a rising edge.
REQ-006 Port ASSERT_OUT  output  1  request acknowledge, a one-cycle pulse per accepted request.
REQ-007 Port OUT_RST  output  1  generated reset, active-low, driven directly from a flop.
REQ-008 Port IS_RESET  output  1  high whenever OUT_RST is low.
REQ-009 Port COUNT  output  8  hold-counter value, unsigned.

Function
REQ-010 The block SHALL implement four states: RESET, SYNC, HOLD and RUN.
REQ-011 The synchronizer SHALL be a chain of stages flops that clears to 0 and shifts in 1 each edge while RST is high.
REQ-012 RESET SHALL go to SYNC on the first rising edge with RST high.
REQ-013 SYNC SHALL go to HOLD on the edge where the last synchronizer bit becomes 1, which is edge number stages after RST rises.
REQ-014 On entry to HOLD, COUNT SHALL load 0.
REQ-015 In HOLD, COUNT SHALL increment by 1 per edge.
REQ-016 HOLD SHALL go to RUN on the edge where COUNT equals hold-1.
REQ-017 From power-on, OUT_RST SHALL rise exactly stages+hold rising edges after the first edge with RST high.
REQ-018 OUT_RST SHALL be high only in RUN.
REQ-019 COUNT SHALL read 0 in RESET, SYNC and RUN.
REQ-020 COUNT SHALL never exceed hold-1 and SHALL never wrap.
REQ-021 An ASSERT_IN sampled high in RUN SHALL be accepted.
REQ-022 On acceptance in RUN, OUT_RST SHALL go low after that same edge.
REQ-023 On acceptance in RUN, the state SHALL go to HOLD with COUNT=0, and OUT_RST SHALL rise again hold edges later.
REQ-024 An ASSERT_IN sampled high in HOLD SHALL be accepted.
REQ-025 On acceptance in HOLD, COUNT SHALL restart at 0 and the full hold period SHALL begin again.
REQ-026 ASSERT_IN held high continuously SHALL keep OUT_RST low indefinitely.
REQ-027 An ASSERT_IN high in RESET or SYNC SHALL be ignored, with no acknowledge.
REQ-028 ASSERT_OUT SHALL be high for the one cycle after each accepted ASSERT_IN edge.
REQ-029 ASSERT_OUT SHALL be high every cycle while requests are accepted back-to-back.
REQ-030 A request accepted on the same edge as HOLD->RUN SHALL take priority: the state stays in HOLD, COUNT=0 and OUT_RST stays low.
REQ-031 The hold counter SHALL be 8 bits wide and zero-extended to COUNT.

Reset
REQ-032 RST low SHALL immediately and asynchronously force the following, independent of CLK: state=RESET, synchronizer=0, COUNT=0, OUT_RST=0, IS_RESET=1, ASSERT_OUT=0.
REQ-033 RST low in any state, including mid-HOLD and mid-SYNC, SHALL abort the sequence, and the full stages+hold sequence SHALL restart after RST rises.
REQ-034 RST pulses shorter than one cycle SHALL still take full effect.

Verification
REQ-035 Power-on, stages=2, hold=8, RST rises before edge 1 -> OUT_RST rises after edge 10; COUNT steps 0..7 over edges 2..9.
REQ-036 In RUN, ASSERT_IN high for one cycle at edge N -> OUT_RST low after N, ASSERT_OUT high for cycle N+1 only, OUT_RST high after edge N+8.
REQ-037 ASSERT_IN pulsed again when COUNT=5 in HOLD -> COUNT returns to 0, a second ASSERT_OUT pulse, and OUT_RST rises 8 edges after the second request.
REQ-038 RST dropped asynchronously mid-HOLD (COUNT=4), then released -> all outputs go to reset values at once, then a full 10-edge sequence.
REQ-039 ASSERT_IN high during SYNC -> no ASSERT_OUT, and timing is identical to REQ-035.
REQ-040 Request coincident with the HOLD->RUN edge (COUNT=7) -> OUT_RST stays low, COUNT=0, and release occurs 8 edges later.
